// File: rtl/adc_ddr_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_pkg
// Purpose  : Shared definitions for the ADC DDR capture front-end: checker
//            mode encodings, default lock/error-counter sizing and a helper
//            that folds the reserved mode onto normal operation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_FIXED  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int DEF_LOCK_COUNT = 64;
  localparam int DEF_ERRCNT_W   = 16;

  // The reserved encoding behaves exactly like normal mode.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_NORMAL : mode_e'(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_ddr_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_ddr_capture_if
// Purpose  : Data-path bundle of the capture block: per-lane IDDR outputs in,
//            formatted/decimated sample stream out.
// Ports    : lane_rise/lane_fall [pLANES] - IDDR Q1/Q2 per lane
//            adc_data [2*pLANES]          - formatted, decimated sample
//            adc_valid                    - adc_data qualifier
//            modport master : lane driver / sample consumer
//            modport slave  : capture block
// Revision : 1.0 - initial release
// ============================================================================
interface adc_ddr_capture_if #(
  parameter int pLANES = 6
) ();
  logic [pLANES-1:0]   lane_rise;
  logic [pLANES-1:0]   lane_fall;
  logic [2*pLANES-1:0] adc_data;
  logic                adc_valid;

  modport master (output lane_rise, output lane_fall, input  adc_data, input  adc_valid);
  modport slave  (input  lane_rise, input  lane_fall, output adc_data, output adc_valid);
endinterface
`default_nettype wire

// File: rtl/adc_ddr_capture_pattern_check.sv
`default_nettype none
// ============================================================================
// Module   : adc_pattern_check
// Purpose  : Ramp / fixed test-pattern checker on the raw assembled sample.
//            Tracks a run of consecutive good samples for lock, sticky
//            per-lane error flags and a saturating mismatch counter.
// Ports    : clk_adc, reset_n      - clock, async active-low reset
//            sample_i, sample_vld_i - raw sample and its qualifier
//            cfg_mode_i, cfg_pattern_i, clear_errors_i - configuration
//            pattern_lock_o, lane_err_o, err_count_o   - status
// Revision : 1.0 - initial release
// ============================================================================
module adc_pattern_check
  import adc_capture_pkg::*;
#(
  parameter int pLANES      = 6,
  parameter int pLOCK_COUNT = DEF_LOCK_COUNT,
  parameter int pERRCNT_W   = DEF_ERRCNT_W
) (
  input  logic                   clk_adc,
  input  logic                   reset_n,
  input  logic [2*pLANES-1:0]    sample_i,
  input  logic                   sample_vld_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [2*pLANES-1:0]    cfg_pattern_i,
  input  logic                   clear_errors_i,
  output logic                   pattern_lock_o,
  output logic [pLANES-1:0]      lane_err_o,
  output logic [pERRCNT_W-1:0]   err_count_o
);
  localparam int pW    = 2*pLANES;
  localparam int RUN_W = $clog2(pLOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(pLOCK_COUNT);

  mode_e                mode, mode_prev_q;
  logic                 mode_chg;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 seeded_q, seeded_d;
  logic [pW-1:0]        exp_q, exp_d, expected, mism;
  logic                 lock_q, lock_d;
  logic [pLANES-1:0]    lane_err_q, lane_err_d;
  logic [pERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  wire  [pLANES-1:0]    lane_hit;

  assign mode     = norm_mode(cfg_mode_i);
  assign mode_chg = (mode != mode_prev_q);

  genvar i;
  for (i = 0; i < pLANES; i++) begin : g_lane_hit
    assign lane_hit[i] = mism[2*i] | mism[2*i+1];
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      mode_prev_q <= MODE_NORMAL;
      run_q       <= '0;
      seeded_q    <= 1'b0;
      exp_q       <= '0;
      lock_q      <= 1'b0;
      lane_err_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      mode_prev_q <= mode;
      run_q       <= run_d;
      seeded_q    <= seeded_d;
      exp_q       <= exp_d;
      lock_q      <= lock_d;
      lane_err_q  <= lane_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    // A mode change discards run and seed before this cycle's sample is used.
    run_d      = mode_chg ? '0 : run_q;
    seeded_d   = seeded_q && !mode_chg;
    exp_d      = exp_q;
    lane_err_d = lane_err_q;
    err_cnt_d  = err_cnt_q;
    expected   = (mode == MODE_RAMP) ? exp_q : cfg_pattern_i;
    mism       = '0;

    if (mode == MODE_NORMAL) begin
      run_d = '0;
    end else if (sample_vld_i) begin
      if (mode == MODE_RAMP && !seeded_d) begin
        seeded_d = 1'b1;
      end else begin
        mism = sample_i ^ expected;
        if (mism == '0) begin
          if (run_d != RUN_MAX) run_d = run_d + RUN_W'(1);
        end else begin
          run_d      = '0;
          lane_err_d = lane_err_d | lane_hit;
          if (err_cnt_d != '1) err_cnt_d = err_cnt_d + pERRCNT_W'(1);
        end
      end
      // Ramp expectation always follows the received value, so an error
      // re-seeds rather than leaving the checker permanently out of step.
      exp_d = sample_i + pW'(1);
    end

    if (clear_errors_i) begin
      lane_err_d = '0;
      err_cnt_d  = '0;
    end
  end

  assign lock_d         = (mode != MODE_NORMAL) && (run_d == RUN_MAX);
  assign pattern_lock_o = lock_q;
  assign lane_err_o     = lane_err_q;
  assign err_count_o    = err_cnt_q;

endmodule
`default_nettype wire

// File: rtl/adc_ddr_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_ddr_capture
// Purpose  : LVDS DDR ADC capture front-end (clk_adc domain). Assembles lane
//            bits into samples (optional edge swap), formats (optional
//            offset binary), decimates, and runs the test-pattern checker.
// Ports    : clk_adc, reset_n            - clock, async active-low reset
//            bus (slave)                 - lane_rise/lane_fall in,
//                                          adc_data/adc_valid out
//            cfg_swap_edges, cfg_offset_binary, cfg_mode, cfg_pattern,
//            cfg_decimate, clear_errors  - configuration
//            pattern_lock, lane_err, err_count - checker status
// Revision : 1.0 - initial release
// ============================================================================
module adc_ddr_capture
  import adc_capture_pkg::*;
#(
  parameter int pLANES      = 6,
  parameter int pLOCK_COUNT = DEF_LOCK_COUNT,
  parameter int pERRCNT_W   = DEF_ERRCNT_W,
  parameter int pDEC_W      = 8
) (
  input  logic                   clk_adc,
  input  logic                   reset_n,
  adc_ddr_capture_if.slave       bus,
  input  logic                   cfg_swap_edges,
  input  logic                   cfg_offset_binary,
  input  logic [1:0]             cfg_mode,
  input  logic [2*pLANES-1:0]    cfg_pattern,
  input  logic [pDEC_W-1:0]      cfg_decimate,
  input  logic                   clear_errors,
  output logic                   pattern_lock,
  output logic [pLANES-1:0]      lane_err,
  output logic [pERRCNT_W-1:0]   err_count
);
  localparam int pW = 2*pLANES;

  wire  [pW-1:0]     raw_d;
  logic [pW-1:0]     raw_q, fmt_d, fmt_q, data_d, data_q;
  // fill_q[0]: raw_q holds a real sample, fill_q[1]: fmt_q does.
  logic [1:0]        fill_q;
  logic [pDEC_W-1:0] dec_cnt_q, dec_cnt_d, dec_prev_q;
  logic              valid_d, valid_q;

  genvar i;
  for (i = 0; i < pLANES; i++) begin : g_lane
    assign raw_d[2*i]   = cfg_swap_edges ? bus.lane_fall[i] : bus.lane_rise[i];
    assign raw_d[2*i+1] = cfg_swap_edges ? bus.lane_rise[i] : bus.lane_fall[i];
  end

  assign fmt_d = raw_q ^ {cfg_offset_binary, {(pW-1){1'b0}}};

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (cfg_decimate != dec_prev_q)
      dec_cnt_d = '0;
    else if (fill_q[1])
      dec_cnt_d = (dec_cnt_q >= cfg_decimate) ? '0 : dec_cnt_q + pDEC_W'(1);
  end

  assign valid_d = fill_q[1] && (dec_cnt_q == '0);
  assign data_d  = valid_d ? fmt_q : data_q;

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      raw_q      <= '0;
      fmt_q      <= '0;
      fill_q     <= '0;
      dec_cnt_q  <= '0;
      dec_prev_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      raw_q      <= raw_d;
      fmt_q      <= fmt_d;
      fill_q     <= {fill_q[0], 1'b1};
      dec_cnt_q  <= dec_cnt_d;
      dec_prev_q <= cfg_decimate;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.adc_data  = data_q;
  assign bus.adc_valid = valid_q;

  adc_pattern_check #(
    .pLANES      (pLANES),
    .pLOCK_COUNT (pLOCK_COUNT),
    .pERRCNT_W   (pERRCNT_W)
  ) u_check (
    .clk_adc        (clk_adc),
    .reset_n        (reset_n),
    .sample_i       (raw_q),
    .sample_vld_i   (fill_q[0]),
    .cfg_mode_i     (cfg_mode),
    .cfg_pattern_i  (cfg_pattern),
    .clear_errors_i (clear_errors),
    .pattern_lock_o (pattern_lock),
    .lane_err_o     (lane_err),
    .err_count_o    (err_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_adc_ddr_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_ddr_capture
// Purpose  : Self-checking bench for adc_ddr_capture against a sample-level
//            reference model, plus hand-computed checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_ddr_capture;
  localparam int L    = 6;
  localparam int W    = 12;
  localparam int LOCK = 64;
  localparam int EW   = 16;
  localparam int DW   = 8;

  logic          clk_adc = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_swap_edges = 1'b0;
  logic          cfg_offset_binary = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [W-1:0]  cfg_pattern = '0;
  logic [DW-1:0] cfg_decimate = '0;
  logic          clear_errors = 1'b0;
  logic          pattern_lock;
  logic [L-1:0]  lane_err;
  logic [EW-1:0] err_count;

  adc_ddr_capture_if #(.pLANES(L)) bus ();

  adc_ddr_capture #(.pLANES(L), .pLOCK_COUNT(LOCK), .pERRCNT_W(EW), .pDEC_W(DW)) dut (
    .clk_adc           (clk_adc),
    .reset_n           (reset_n),
    .bus               (bus),
    .cfg_swap_edges    (cfg_swap_edges),
    .cfg_offset_binary (cfg_offset_binary),
    .cfg_mode          (cfg_mode),
    .cfg_pattern       (cfg_pattern),
    .cfg_decimate      (cfg_decimate),
    .clear_errors      (clear_errors),
    .pattern_lock      (pattern_lock),
    .lane_err          (lane_err),
    .err_count         (err_count)
  );

  always #5 clk_adc = ~clk_adc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (per clock edge, sample level) --------
  bit           m_started = 0;
  int           m_edge = 0;
  logic [W-1:0] m_raw_prev = '0, m_fmt_prev = '0, m_data = '0;
  logic         m_valid = 0;
  int           m_anchor = 3, m_dec = 0;
  logic [DW-1:0] m_dec_prev = '0;
  int           m_mode_prev = 0, m_run = 0, m_cnt = 0, md;
  bit           m_seeded = 0;
  logic [W-1:0] m_exp = '0, r, expv, mism;
  logic         m_lock = 0;
  logic [L-1:0] m_lane = '0;

  // Sample as wired (rise = even bit, fall = odd bit); swap exchanges pairs.
  function automatic logic [W-1:0] assemble(input logic [L-1:0] rise, input logic [L-1:0] fall,
                                            input logic swap);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < L; i++) begin
      s[2*i]   = rise[i];
      s[2*i+1] = fall[i];
    end
    if (swap) s = ((s & 12'h555) << 1) | ((s >> 1) & 12'h555);
    return s;
  endfunction

  always @(posedge clk_adc) begin
    if (!reset_n) begin
      m_started = 1; m_edge = 0; m_raw_prev = '0; m_fmt_prev = '0; m_data = '0;
      m_valid = 0; m_anchor = 3; m_dec = 0; m_dec_prev = '0; m_mode_prev = 0;
      m_run = 0; m_cnt = 0; m_seeded = 0; m_exp = '0; m_lock = 0; m_lane = '0;
    end else begin
      m_edge++;
      // output: one sample every (decimate+1), counted from the latest anchor
      m_valid = (m_edge >= m_anchor) && (((m_edge - m_anchor) % (m_dec + 1)) == 0);
      if (m_valid) m_data = m_fmt_prev;
      if (cfg_decimate != m_dec_prev) begin
        m_anchor = (m_edge + 1 > 3) ? m_edge + 1 : 3;
        m_dec    = int'(cfg_decimate);
      end
      m_dec_prev = cfg_decimate;

      // checker works on the sample assembled on the previous edge
      md = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
      if (md != m_mode_prev) begin m_run = 0; m_seeded = 0; end
      m_mode_prev = md;
      if (md == 0) begin
        m_run = 0;
      end else if (m_edge >= 2) begin
        if (md == 1 && !m_seeded) begin
          m_seeded = 1;
        end else begin
          expv = (md == 1) ? m_exp : cfg_pattern;
          mism = m_raw_prev ^ expv;
          if (mism == 0) begin
            m_run = (m_run < LOCK) ? m_run + 1 : LOCK;
          end else begin
            m_run = 0;
            for (int i = 0; i < L; i++) if (mism[2*i +: 2] != 2'b00) m_lane[i] = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end
        end
        m_exp = m_raw_prev + 12'd1;
      end
      if (clear_errors) begin m_lane = '0; m_cnt = 0; end
      m_lock = (md != 0) && (m_run == LOCK);

      m_fmt_prev = m_raw_prev ^ (cfg_offset_binary ? 12'h800 : 12'h000);
      r = assemble(bus.lane_rise, bus.lane_fall, cfg_swap_edges);
      m_raw_prev = r;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_adc) begin
    if (m_started) begin
      check("adc_valid",    32'(bus.adc_valid), 32'(m_valid));
      check("adc_data",     32'(bus.adc_data),  32'(m_data));
      check("pattern_lock", 32'(pattern_lock),  32'(m_lock));
      check("lane_err",     32'(lane_err),      32'(m_lane));
      check("err_count",    32'(err_count),     32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] rv = '0;

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic put(input logic [W-1:0] v);
    for (int i = 0; i < L; i++) begin
      bus.lane_rise[i] = v[2*i];
      bus.lane_fall[i] = v[2*i+1];
    end
  endtask

  task automatic ramp_steps(input int n);
    for (int k = 0; k < n; k++) begin
      put(rv);
      rv = rv + 12'd1;
      tick();
    end
  endtask

  initial begin
    int nvalid;
    logic have_prev;
    logic [W-1:0] prev, step;

    put('0);
    repeat (3) tick();
    reset_n = 1'b1;
    bus.lane_rise = 6'h2A;
    bus.lane_fall = 6'h15;

    // pipeline fill and first output
    tick(); tick();
    check("fill_valid", 32'(bus.adc_valid), 32'd0);
    tick();
    check("first_valid", 32'(bus.adc_valid), 32'd1);
    check("first_data",  32'(bus.adc_data),  32'h666);
    check("first_laneerr", 32'(lane_err), 32'd0);
    check("first_errcnt",  32'(err_count), 32'd0);

    // edge swap and offset binary
    cfg_swap_edges = 1'b1;
    repeat (3) tick();
    check("swap_data", 32'(bus.adc_data), 32'h999);
    cfg_offset_binary = 1'b1;
    repeat (3) tick();
    check("offset_data", 32'(bus.adc_data), 32'h199);
    cfg_swap_edges = 1'b0;
    cfg_offset_binary = 1'b0;

    // random normal-mode traffic with occasional format changes
    repeat (60) begin
      bus.lane_rise = L'($urandom);
      bus.lane_fall = L'($urandom);
      if ($urandom_range(0, 7) == 0) cfg_swap_edges = 1'($urandom);
      if ($urandom_range(0, 7) == 0) cfg_offset_binary = 1'($urandom);
      tick();
    end
    cfg_swap_edges = 1'b0;
    cfg_offset_binary = 1'b0;

    // ramp lock across the 0xFFF -> 0x000 wrap
    rv = 12'hFBE;
    ramp_steps(2);
    cfg_mode = 2'd1;
    while (rv != 12'h041) ramp_steps(1);
    ramp_steps(2);
    check("ramp_lock", 32'(pattern_lock), 32'd1);
    check("ramp_errcnt", 32'(err_count), 32'd0);

    // bit-5 error at 0x050: the bad value re-seeds the expectation, so the
    // following good sample also mismatches in bit 5 -> two errors, lane 2
    while (rv != 12'h050) ramp_steps(1);
    put(rv ^ 12'h020);
    rv = rv + 12'd1;
    tick();
    ramp_steps(3);
    check("inj_laneerr", 32'(lane_err), 32'h04);
    check("inj_errcnt",  32'(err_count), 32'd2);
    check("inj_lockdrop", 32'(pattern_lock), 32'd0);
    ramp_steps(70);
    check("relock", 32'(pattern_lock), 32'd1);

    // clear coincident with a mismatch: clear wins
    put(rv ^ 12'h400);
    rv = rv + 12'd1;
    tick();
    clear_errors = 1'b1;
    ramp_steps(1);
    clear_errors = 1'b0;
    check("clear_errcnt",  32'(err_count), 32'd0);
    check("clear_laneerr", 32'(lane_err),  32'd0);

    // random ramp errors and clears, then reserved mode and back
    repeat (300) begin
      logic [W-1:0] v;
      v = rv;
      if ($urandom_range(0, 15) == 0) v = v ^ (12'd1 << $urandom_range(0, 11));
      put(v);
      rv = rv + 12'd1;
      clear_errors = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear_errors = 1'b0;
    cfg_mode = 2'd3;
    ramp_steps(5);
    check("rsvd_lock", 32'(pattern_lock), 32'd0);
    cfg_mode = 2'd1;
    ramp_steps(80);

    // fixed pattern: random hits and misses, then saturation
    cfg_mode = 2'd2;
    cfg_pattern = 12'hA5A;
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    repeat (100) begin
      put(($urandom_range(0, 7) == 0) ? W'($urandom) : 12'hA5A);
      tick();
    end
    put('0);
    repeat (66000) tick();
    check("sat_errcnt",  32'(err_count), 32'hFFFF);
    check("sat_laneerr", 32'(lane_err),  32'h3F);
    check("sat_lock",    32'(pattern_lock), 32'd0);

    // decimation by 4 on a ramp
    cfg_mode = 2'd0;
    cfg_decimate = 8'd3;
    rv = '0;
    ramp_steps(8);
    nvalid = 0;
    have_prev = 1'b0;
    prev = '0;
    for (int k = 0; k < 40; k++) begin
      ramp_steps(1);
      if (bus.adc_valid) begin
        nvalid++;
        if (have_prev) begin
          step = bus.adc_data - prev;
          check("dec_step", 32'(step), 32'd4);
        end
        have_prev = 1'b1;
        prev = bus.adc_data;
      end
    end
    check("dec_count", 32'(nvalid), 32'd10);

    // switch to no decimation mid-stream: valid every cycle one cycle later
    cfg_decimate = 8'd0;
    ramp_steps(1);
    for (int k = 0; k < 6; k++) begin
      ramp_steps(1);
      check("dec0_valid", 32'(bus.adc_valid), 32'd1);
    end

    // random decimation changes
    repeat (200) begin
      if ($urandom_range(0, 19) == 0) cfg_decimate = DW'($urandom_range(0, 5));
      put(W'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
